// File: rtl/fsab_dma_read_arbiter.sv
// fsab_dma_read_arbiter
//
// Shares one FSAB request port between two DMA read requesters. Requesters
// are granted round-robin, each accepted request is issued on dmac__fsabo_*
// one cycle later as a single-cycle read strobe, and FSAB request credits are
// tracked so the bus is never over-subscribed. Read return data (fsabi_*) is
// not handled here; requesters filter it themselves by did/subdid.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rN_valid / rN_ready      requester N handshake (ready is combinational)
//   rN_subdid/addr/len       requester N request fields, held until accepted
//   dmac__fsabo_*            FSAB request port (read-only use)
//   dmac__fsabo_credit       one returned credit per pulse
//   credits                  current credit count
//   cred_err                 sticky: credit returned while already full
module fsab_dma_read_arbiter #(
   parameter int FSAB_REQ_HI  = 0,
   parameter int FSAB_DID_HI  = 3,
   parameter int FSAB_ADDR_HI = 30,
   parameter int FSAB_LEN_HI  = 3,
   parameter int FSAB_DATA_HI = 63,
   parameter int FSAB_MASK_HI = 7,
   parameter logic [FSAB_REQ_HI:0] FSAB_READ    = '0,
   parameter logic [FSAB_DID_HI:0] FSAB_DID_CPU = '0,
   parameter logic [FSAB_DID_HI:0] FSAB_DID     = FSAB_DID_CPU,
   parameter int FSAB_CREDITS = 4,
   parameter int CRED_W       = 3
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    r0_valid,
   output logic                    r0_ready,
   input  logic [FSAB_DID_HI:0]    r0_subdid,
   input  logic [FSAB_ADDR_HI:0]   r0_addr,
   input  logic [FSAB_LEN_HI:0]    r0_len,

   input  logic                    r1_valid,
   output logic                    r1_ready,
   input  logic [FSAB_DID_HI:0]    r1_subdid,
   input  logic [FSAB_ADDR_HI:0]   r1_addr,
   input  logic [FSAB_LEN_HI:0]    r1_len,

   output logic                    dmac__fsabo_valid,
   output logic [FSAB_REQ_HI:0]    dmac__fsabo_mode,
   output logic [FSAB_DID_HI:0]    dmac__fsabo_did,
   output logic [FSAB_DID_HI:0]    dmac__fsabo_subdid,
   output logic [FSAB_ADDR_HI:0]   dmac__fsabo_addr,
   output logic [FSAB_LEN_HI:0]    dmac__fsabo_len,
   output logic [FSAB_DATA_HI:0]   dmac__fsabo_data,
   output logic [FSAB_MASK_HI:0]   dmac__fsabo_mask,
   input  logic                    dmac__fsabo_credit,

   output logic [CRED_W-1:0]       credits,
   output logic                    cred_err
);

   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FSAB_CREDITS);

   // Next credit count with saturation at CRED_MAX. The top bit flags a
   // credit that arrived with nowhere to go (count already full, no accept).
   // Underflow cannot happen: accepts only occur while cur != 0.
   function automatic logic [CRED_W:0] credit_next(
      input logic [CRED_W-1:0] cur,
      input logic              acc,
      input logic              ret
   );
      logic [CRED_W:0] res;
      res = {1'b0, cur};
      if (acc && !ret)
         res = {1'b0, cur - 1'b1};
      else if (ret && !acc) begin
         if (cur == CRED_MAX)
            res = {1'b1, cur};
         else
            res = {1'b0, cur + 1'b1};
      end
      return res;
   endfunction

   logic                  rr_last;
   logic                  can_grant;
   logic                  accept_p0;
   logic                  winner_p0;
   logic [CRED_W:0]       cred_upd;

   logic                  vld_p1;
   logic [FSAB_REQ_HI:0]  mode_p1;
   logic [FSAB_DID_HI:0]  did_p1;
   logic [FSAB_DID_HI:0]  subdid_p1;
   logic [FSAB_ADDR_HI:0] addr_p1;
   logic [FSAB_LEN_HI:0]  len_p1;

   // ---- Stage p0: combinational arbitration and credit update ----
   // Grant only depends on the registered count, so a credit returned this
   // cycle cannot enable a grant until the next one.
   always_comb begin
      can_grant = (credits != '0);
      r0_ready  = can_grant && r0_valid && (!r1_valid || rr_last);
      r1_ready  = can_grant && r1_valid && (!r0_valid || !rr_last);
      accept_p0 = r0_ready || r1_ready;
      winner_p0 = r1_ready;
      cred_upd  = credit_next(credits, accept_p0, dmac__fsabo_credit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits  <= CRED_MAX;
         cred_err <= 1'b0;
         rr_last  <= 1'b1;
      end else begin
         credits <= cred_upd[CRED_W-1:0];
         if (cred_upd[CRED_W])
            cred_err <= 1'b1;
         if (accept_p0)
            rr_last <= winner_p0;
      end
   end

   // ---- Stage p1: registered request issue ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         mode_p1   <= '0;
         did_p1    <= '0;
         subdid_p1 <= '0;
         addr_p1   <= '0;
         len_p1    <= '0;
      end else begin
         vld_p1 <= accept_p0;
         if (accept_p0) begin
            mode_p1   <= FSAB_READ;
            did_p1    <= FSAB_DID;
            subdid_p1 <= winner_p0 ? r1_subdid : r0_subdid;
            addr_p1   <= winner_p0 ? r1_addr   : r0_addr;
            len_p1    <= winner_p0 ? r1_len    : r0_len;
         end
      end
   end

   assign dmac__fsabo_valid  = vld_p1;
   assign dmac__fsabo_mode   = mode_p1;
   assign dmac__fsabo_did    = did_p1;
   assign dmac__fsabo_subdid = subdid_p1;
   assign dmac__fsabo_addr   = addr_p1;
   assign dmac__fsabo_len    = len_p1;
   assign dmac__fsabo_data   = '0;
   assign dmac__fsabo_mask   = '0;

endmodule

// File: tb/tb_fsab_dma_read_arbiter.sv
// Testbench for fsab_dma_read_arbiter: directed stimulus with a scoreboard.
// Expected issued requests are queued when acceptance is expected; a monitor
// pops and compares every cycle the DUT presents dmac__fsabo_valid.
module tb_fsab_dma_read_arbiter;

   localparam logic [3:0] DID = 4'h5;

   typedef struct packed {
      logic [3:0]  subdid;
      logic [30:0] addr;
      logic [3:0]  len;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r1_valid;
   logic        r0_ready, r1_ready;
   logic [3:0]  r0_subdid, r1_subdid;
   logic [30:0] r0_addr, r1_addr;
   logic [3:0]  r0_len, r1_len;
   logic        fvalid;
   logic [0:0]  fmode;
   logic [3:0]  fdid, fsubdid;
   logic [30:0] faddr;
   logic [3:0]  flen;
   logic [63:0] fdata;
   logic [7:0]  fmask;
   logic        fcredit;
   logic [2:0]  credits;
   logic        cred_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   req_t exp_q[$];

   fsab_dma_read_arbiter #(
      .FSAB_DID     (DID),
      .FSAB_CREDITS (4),
      .CRED_W       (3)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .r0_valid           (r0_valid),
      .r0_ready           (r0_ready),
      .r0_subdid          (r0_subdid),
      .r0_addr            (r0_addr),
      .r0_len             (r0_len),
      .r1_valid           (r1_valid),
      .r1_ready           (r1_ready),
      .r1_subdid          (r1_subdid),
      .r1_addr            (r1_addr),
      .r1_len             (r1_len),
      .dmac__fsabo_valid  (fvalid),
      .dmac__fsabo_mode   (fmode),
      .dmac__fsabo_did    (fdid),
      .dmac__fsabo_subdid (fsubdid),
      .dmac__fsabo_addr   (faddr),
      .dmac__fsabo_len    (flen),
      .dmac__fsabo_data   (fdata),
      .dmac__fsabo_mask   (fmask),
      .dmac__fsabo_credit (fcredit),
      .credits            (credits),
      .cred_err           (cred_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] s, input logic [30:0] a, input logic [3:0] l);
      req_t r;
      r.subdid = s;
      r.addr   = a;
      r.len    = l;
      exp_q.push_back(r);
   endtask

   // Monitor: registered outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && fvalid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", 64'(faddr), 64'hFFFF_FFFF);
         end else begin
            req_t e;
            e = exp_q.pop_front();
            chk("issue_subdid", 64'(fsubdid), 64'(e.subdid));
            chk("issue_addr",   64'(faddr),   64'(e.addr));
            chk("issue_len",    64'(flen),    64'(e.len));
            chk("issue_mode",   64'(fmode),   64'h0);
            chk("issue_did",    64'(fdid),    64'(DID));
            chk("issue_data",   64'(fdata),   64'h0);
            chk("issue_mask",   64'(fmask),   64'h0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      r0_valid = 0; r1_valid = 0; fcredit = 0;
      r0_subdid = 0; r0_addr = 0; r0_len = 0;
      r1_subdid = 0; r1_addr = 0; r1_len = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid",   64'(fvalid),   0);
      chk("rst_addr",    64'(faddr),    0);
      chk("rst_did",     64'(fdid),     0);
      chk("rst_credits", 64'(credits),  4);
      chk("rst_cred_err",64'(cred_err), 0);
      chk("rst_r0_ready",64'(r0_ready), 0);
      rst = 1'b0;

      // r0 alone
      @(negedge clk);
      r0_valid = 1; r0_subdid = 4'h2; r0_addr = 31'h100; r0_len = 4'd8;
      #1;
      chk("single_r0_ready", 64'(r0_ready), 1);
      chk("single_r1_ready", 64'(r1_ready), 0);
      push(4'h2, 31'h100, 4'd8);
      @(negedge clk);
      r0_valid = 0;
      #1;
      chk("single_credits", 64'(credits), 3);
      fcredit = 1;
      @(negedge clk);
      fcredit = 0;
      #1;
      chk("single_credit_back", 64'(credits), 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Both valid held: 0,1,0,1 then starve on credits
      r0_subdid = 4'h1; r0_addr = 31'h200; r0_len = 4'd4;
      r1_subdid = 4'h3; r1_addr = 31'h300; r1_len = 4'd2;
      r0_valid = 1; r1_valid = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_credits", 64'(credits), 64'(4 - i));
         chk("rr_r0_ready", 64'(r0_ready), 64'(i % 2 == 0));
         chk("rr_r1_ready", 64'(r1_ready), 64'(i % 2 == 1));
         if (i % 2 == 0) push(4'h1, 31'h200, 4'd4);
         else            push(4'h3, 31'h300, 4'd2);
         @(negedge clk);
      end
      #1;
      chk("empty_credits",  64'(credits),  0);
      chk("empty_r0_ready", 64'(r0_ready), 0);
      chk("empty_r1_ready", 64'(r1_ready), 0);
      @(negedge clk);
      #1;
      chk("empty_no_issue", 64'(fvalid), 0);

      // One credit at zero: no grant same cycle, grant next cycle
      fcredit = 1;
      #1;
      chk("cred0_no_grant", 64'(r0_ready | r1_ready), 0);
      @(negedge clk);
      fcredit = 0;
      #1;
      chk("cred0_credits", 64'(credits), 1);
      chk("cred0_r0_ready", 64'(r0_ready), 1);
      chk("cred0_r1_ready", 64'(r1_ready), 0);
      push(4'h1, 31'h200, 4'd4);
      @(negedge clk);
      r0_valid = 0; r1_valid = 0;
      #1;
      chk("cred0_after", 64'(credits), 0);

      // Accept and credit return together at credits=2
      fcredit = 1;
      @(negedge clk);
      @(negedge clk);
      fcredit = 0;
      #1;
      chk("two_credits", 64'(credits), 2);
      r1_valid = 1; fcredit = 1;
      #1;
      chk("same_r1_ready", 64'(r1_ready), 1);
      push(4'h3, 31'h300, 4'd2);
      @(negedge clk);
      r1_valid = 0; fcredit = 0;
      #1;
      chk("same_credits", 64'(credits), 2);

      // Credit overflow after reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fcredit = 1;
      repeat (5) @(negedge clk);
      fcredit = 0;
      #1;
      chk("ovf_credits",  64'(credits),  4);
      chk("ovf_cred_err", 64'(cred_err), 1);
      repeat (3) @(negedge clk);
      #1;
      chk("ovf_sticky", 64'(cred_err), 1);

      // Reset while an issue is pending
      r0_valid = 1; r0_subdid = 4'h2; r0_addr = 31'h100; r0_len = 4'd8;
      #1;
      chk("rstmid_r0_ready", 64'(r0_ready), 1);
      #2;
      rst = 1'b1; r0_valid = 0;
      #1;
      chk("rstmid_valid",    64'(fvalid),   0);
      chk("rstmid_addr",     64'(faddr),    0);
      chk("rstmid_credits",  64'(credits),  4);
      chk("rstmid_cred_err", 64'(cred_err), 0);
      @(negedge clk);
      #1;
      chk("rstmid_dropped", 64'(fvalid), 0);
      rst = 1'b0;
      r0_subdid = 4'h6; r0_addr = 31'h400; r0_len = 4'd1;
      r1_subdid = 4'h7; r1_addr = 31'h500; r1_len = 4'd3;
      r0_valid = 1; r1_valid = 1;
      #1;
      chk("post_r0_first", 64'(r0_ready), 1);
      chk("post_r1_wait",  64'(r1_ready), 0);
      push(4'h6, 31'h400, 4'd1);
      @(negedge clk);
      #1;
      chk("post_r1_next", 64'(r1_ready), 1);
      chk("post_r0_wait", 64'(r0_ready), 0);
      push(4'h7, 31'h500, 4'd3);
      @(negedge clk);
      r0_valid = 0; r1_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fsab_dma_read_arbiter.md
Name: fsab_dma_read_arbiter

Overview:
- Shares one FSAB request port between two DMA read requesters, e.g. two SimpleDMAReadController-class engines.
- Grants requesters round-robin and issues single-cycle read requests on dmac__fsabo_*.
- Tracks FSAB request credits so the bus is never over-subscribed.
- Does not touch read return data: requesters filter fsabi_* themselves by did/subdid.

Parameters:
- FSAB_CREDITS, 4, initial and maximum number of request credits granted by the FSAB.
- CRED_W, 3, credit counter width; must hold FSAB_CREDITS.
- FSAB_DID, FSAB_DID_CPU, did driven on every request.

Ports:
- clk  in  1  single block clock.
- rst  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 has a read request pending.
- r0_ready  out  1  request 0 accepted this cycle.
- r0_subdid  in  FSAB_DID_HI+1  subdid for requester 0.
- r0_addr  in  FSAB_ADDR_HI+1  read address for requester 0.
- r0_len  in  FSAB_LEN_HI+1  burst length for requester 0.
- r1_valid / r1_ready / r1_subdid / r1_addr / r1_len: same as r0_*, for requester 1.
- dmac__fsabo_valid  out  1  request strobe.
- dmac__fsabo_mode  out  FSAB_REQ_HI+1  always FSAB_READ.
- dmac__fsabo_did  out  FSAB_DID_HI+1  = FSAB_DID.
- dmac__fsabo_subdid  out  FSAB_DID_HI+1  subdid of the granted requester.
- dmac__fsabo_addr  out  FSAB_ADDR_HI+1  address of the granted requester.
- dmac__fsabo_len  out  FSAB_LEN_HI+1  length of the granted requester.
- dmac__fsabo_data  out  FSAB_DATA_HI+1  always 0.
- dmac__fsabo_mask  out  FSAB_MASK_HI+1  always 0.
- dmac__fsabo_credit  in  1  one credit returned per pulse.
- credits  out  CRED_W  current credit count, for debug and SPAM readback.
- cred_err  out  1  sticky; a credit arrived while the count was at FSAB_CREDITS.

Behaviour:
- Reset (rst=1, async):
  - all dmac__fsabo_* outputs = 0.
  - credits = FSAB_CREDITS.
  - rr_last = 1, so requester 0 wins the first arbitration.
  - cred_err = 0.
- Grant condition (combinational in cycle N): grant is possible when credits != 0 and any rX_valid=1.
  - Only one valid: that requester wins.
  - Both valid: the requester != rr_last wins.
  - rX_ready is asserted only for the winner, in the same cycle; acceptance = rX_valid & rX_ready.
- Issue (cycle N+1, registered):
  - dmac__fsabo_valid=1 for exactly one cycle.
  - subdid/addr/len are the winner's values as sampled in cycle N.
  - mode=FSAB_READ, did=FSAB_DID.
  - rr_last <= winner.
  - Back-to-back grants are allowed, so valid may stay high on consecutive cycles, one request per cycle.
- Non-issue cycles: dmac__fsabo_valid=0. addr/len/subdid hold their last values; their contents are don't-care.
- Credit arithmetic, per cycle: credits_next = credits - accept + dmac__fsabo_credit.
  - Accept and credit return in the same cycle: the count is unchanged.
  - Credit return while credits==FSAB_CREDITS and no accept: the count saturates at FSAB_CREDITS and cred_err <= 1. cred_err is cleared only by rst.
  - credits==0: no rX_ready. A credit returning in cycle N does not enable a grant until cycle N+1.
- Requesters must hold rX_valid and their fields stable until accepted. The arbiter does not check this.
- rX_valid dropped before acceptance: nothing is issued for that requester.
- rst mid-operation: any pending issue is dropped. Credits return to FSAB_CREDITS. The requester and bus must be reset together.
- Latency: 1 cycle from acceptance to dmac__fsabo_valid.
- Throughput: 1 request per cycle while credits remain.

Test Plan:
- Reset, then r0 alone: r0_valid=1, addr=0x100, len=8 → r0_ready same cycle; next cycle fsabo_valid=1, addr=0x100, len=8, mode=FSAB_READ; credits 4→3.
- Both valid held continuously, no credit return → grants alternate 0,1,0,1. After 4 issues credits=0, both ready=0, fsabo_valid stays 0.
- credits=0, one credit pulse in cycle N → first grant in cycle N+1, fsabo_valid in N+2, credits back to 0.
- Accept and dmac__fsabo_credit in the same cycle with credits=2 → credits stays 2; request issued.
- 5 credit pulses after reset with no requests → credits stays 4, cred_err=1 and remains 1 until rst.
- Assert rst while fsabo_valid is pending after an accept → all outputs 0 immediately, credits=4. After release, r0 is granted first.
